// File: rtl/muldiv_seq.sv
// Sequential RISC-V M-extension unit: radix-2 shift-add multiply and restoring divide
// on one shared adder. The result arrives 34 cycles after accept, or 2 cycles on the divide fast paths.
module muldiv_seq #(
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [2:0]        op,
  input  logic [DATA_W-1:0] src1,
  input  logic [DATA_W-1:0] src2,
  input  logic [4:0]        gprs_waddr_i,
  input  logic              flush,
  output logic              stall,
  output logic              done,
  output logic [4:0]        gprs_waddr_o,
  output logic [DATA_W-1:0] gprs_wdata_o
);
  typedef enum logic [1:0] {S_IDLE, S_CALC, S_FIX, S_DONE} state_t;

  localparam logic [4:0]        LAST_STEP = 5'(DATA_W - 1);
  localparam logic [DATA_W-1:0] MIN_NEG   = {1'b1, {(DATA_W-1){1'b0}}};

  state_t              state_q, state_d;
  logic [2:0]          op_q, op_d;
  logic [4:0]          waddr_q, waddr_d;
  logic [4:0]          cnt_q, cnt_d;
  logic                neg_q, neg_d;
  logic                rneg_q, rneg_d;
  logic [DATA_W-1:0]   b_q, b_d;
  logic [DATA_W-1:0]   hi_q, hi_d;
  logic [DATA_W-1:0]   lo_q, lo_d;
  logic [DATA_W-1:0]   wdata_q, wdata_d;
  logic [4:0]          waddr_o_q, waddr_o_d;

  logic                s1_signed, s2_signed, src1_neg, src2_neg;
  logic [DATA_W-1:0]   mag1, mag2;
  logic                div_zero, div_ovf, accept;
  logic [DATA_W:0]     add_a, add_b, add_s, mul_sum;
  logic [2*DATA_W-1:0] prod_raw, prod_fix;
  logic [DATA_W-1:0]   quo_fix, rem_fix, result;

  always_comb begin
    s1_signed = 1'b0;
    s2_signed = 1'b0;
    case (op)
      3'd1, 3'd4, 3'd6: begin
        s1_signed = 1'b1;
        s2_signed = 1'b1;
      end
      3'd2:    s1_signed = 1'b1;
      default: ;
    endcase
  end

  assign src1_neg = s1_signed & src1[DATA_W-1];
  assign src2_neg = s2_signed & src2[DATA_W-1];
  assign mag1     = src1_neg ? -src1 : src1;
  assign mag2     = src2_neg ? -src2 : src2;
  assign div_zero = op[2] & (src2 == '0);
  assign div_ovf  = ((op == 3'd4) || (op == 3'd6)) && (src1 == MIN_NEG) && (src2 == '1);
  assign accept   = (state_q == S_IDLE) & start & ~flush;

  // Shared adder: add multiplicand for multiply, subtract divisor (a + ~b + 1) for divide.
  assign add_a   = op_q[2] ? {hi_q, lo_q[DATA_W-1]} : {1'b0, hi_q};
  assign add_b   = op_q[2] ? ~{1'b0, b_q} : {1'b0, b_q};
  assign add_s   = add_a + add_b + {{DATA_W{1'b0}}, op_q[2]};
  assign mul_sum = lo_q[0] ? add_s : {1'b0, hi_q};

  assign prod_raw = {hi_q, lo_q};
  assign prod_fix = neg_q ? -prod_raw : prod_raw;
  assign quo_fix  = neg_q ? -lo_q : lo_q;
  assign rem_fix  = rneg_q ? -hi_q : hi_q;

  always_comb begin
    result = '0;
    case (op_q)
      3'd0:             result = prod_fix[DATA_W-1:0];
      3'd1, 3'd2, 3'd3: result = prod_fix[2*DATA_W-1:DATA_W];
      3'd4, 3'd5:       result = quo_fix;
      default:          result = rem_fix;
    endcase
  end

  // FSM: state register
  always_ff @(posedge clk) begin
    if (rst) state_q <= S_IDLE;
    else     state_q <= state_d;
  end

  // FSM: next state
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: if (accept) state_d = (div_zero || div_ovf) ? S_FIX : S_CALC;
      S_CALC: if (cnt_q == LAST_STEP) state_d = S_FIX;
      S_FIX:  state_d = S_DONE;
      S_DONE: state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
    if (flush) state_d = S_IDLE;
  end

  // FSM: outputs
  always_comb begin
    stall = ~rst & ((state_q == S_CALC) || (state_q == S_FIX) ||
                    ((state_q == S_IDLE) && start && !flush));
    done  = (state_q == S_DONE);
  end

  always_comb begin
    op_d      = op_q;
    waddr_d   = waddr_q;
    cnt_d     = cnt_q;
    neg_d     = neg_q;
    rneg_d    = rneg_q;
    b_d       = b_q;
    hi_d      = hi_q;
    lo_d      = lo_q;
    wdata_d   = wdata_q;
    waddr_o_d = waddr_o_q;
    case (state_q)
      S_IDLE: if (accept) begin
        op_d    = op;
        waddr_d = gprs_waddr_i;
        cnt_d   = '0;
        hi_d    = '0;
        neg_d   = src1_neg ^ src2_neg;
        rneg_d  = op[2] & src1_neg;
        lo_d    = op[2] ? mag1 : mag2;
        b_d     = op[2] ? mag2 : mag1;
        // Fast paths preload the final, already-signed result.
        if (div_zero) begin
          hi_d   = src1;
          lo_d   = '1;
          neg_d  = 1'b0;
          rneg_d = 1'b0;
        end else if (div_ovf) begin
          hi_d   = '0;
          lo_d   = MIN_NEG;
          neg_d  = 1'b0;
          rneg_d = 1'b0;
        end
      end
      S_CALC: begin
        cnt_d = cnt_q + 5'd1;
        if (op_q[2]) begin
          if (add_s[DATA_W]) begin
            hi_d = {hi_q[DATA_W-2:0], lo_q[DATA_W-1]};
            lo_d = {lo_q[DATA_W-2:0], 1'b0};
          end else begin
            hi_d = add_s[DATA_W-1:0];
            lo_d = {lo_q[DATA_W-2:0], 1'b1};
          end
        end else begin
          hi_d = mul_sum[DATA_W:1];
          lo_d = {mul_sum[0], lo_q[DATA_W-1:1]};
        end
      end
      S_FIX: if (!flush) begin
        wdata_d   = result;
        waddr_o_d = waddr_q;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      op_q      <= '0;
      waddr_q   <= '0;
      cnt_q     <= '0;
      neg_q     <= 1'b0;
      rneg_q    <= 1'b0;
      b_q       <= '0;
      hi_q      <= '0;
      lo_q      <= '0;
      wdata_q   <= '0;
      waddr_o_q <= '0;
    end else begin
      op_q      <= op_d;
      waddr_q   <= waddr_d;
      cnt_q     <= cnt_d;
      neg_q     <= neg_d;
      rneg_q    <= rneg_d;
      b_q       <= b_d;
      hi_q      <= hi_d;
      lo_q      <= lo_d;
      wdata_q   <= wdata_d;
      waddr_o_q <= waddr_o_d;
    end
  end

  assign gprs_wdata_o = wdata_q;
  assign gprs_waddr_o = waddr_o_q;

endmodule

// File: tb/tb_muldiv_seq.sv
// Bench for muldiv_seq: an arithmetic reference model drives a per-cycle compare,
// and directed vectors carry hand-computed results and latencies.
module tb_muldiv_seq;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic [2:0]  op = '0;
  logic [31:0] src1 = '0;
  logic [31:0] src2 = '0;
  logic [4:0]  gprs_waddr_i = '0;
  logic        flush = 1'b0;
  logic        stall, done;
  logic [4:0]  gprs_waddr_o;
  logic [31:0] gprs_wdata_o;

  int n_pass = 0;
  int n_total = 0;
  bit chk_en = 0;

  muldiv_seq #(.DATA_W(32)) dut (
    .clk(clk), .rst(rst), .start(start), .op(op), .src1(src1), .src2(src2),
    .gprs_waddr_i(gprs_waddr_i), .flush(flush), .stall(stall), .done(done),
    .gprs_waddr_o(gprs_waddr_o), .gprs_wdata_o(gprs_wdata_o)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
  endtask

  function automatic bit is_fast(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b);
    return o[2] && ((b == 32'h0) ||
           (((o == 3'd4) || (o == 3'd6)) && (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF)));
  endfunction

  // Reference arithmetic straight from the RISC-V M definitions.
  function automatic logic [31:0] ref_result(input logic [2:0] o, input logic [31:0] a,
                                             input logic [31:0] b);
    logic [63:0] p;
    longint sa, sb, ua, ub;
    bit ovf;
    sa  = longint'($signed(a));
    sb  = longint'($signed(b));
    ua  = longint'({32'h0, a});
    ub  = longint'({32'h0, b});
    ovf = (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF);
    p   = '0;
    case (o)
      3'd0: begin p = 64'(ua * ub); return p[31:0]; end
      3'd1: begin p = 64'(sa * sb); return p[63:32]; end
      3'd2: begin p = 64'(sa * ub); return p[63:32]; end
      3'd3: begin p = 64'(ua * ub); return p[63:32]; end
      3'd4: begin
        if (b == 0) return 32'hFFFF_FFFF;
        if (ovf) return 32'h8000_0000;
        return 32'(sa / sb);
      end
      3'd5: begin
        if (b == 0) return 32'hFFFF_FFFF;
        return 32'(ua / ub);
      end
      3'd6: begin
        if (b == 0) return a;
        if (ovf) return 32'h0;
        return 32'(sa % sb);
      end
      default: begin
        if (b == 0) return a;
        return 32'(ua % ub);
      end
    endcase
  endfunction

  // Timing model: busy for (latency-1) edges after accept, then a one-cycle done.
  bit          m_busy = 0;
  bit          m_done = 0;
  int          m_left = 0;
  logic [31:0] m_res = '0;
  logic [4:0]  m_addr = '0;
  logic [31:0] m_out_data = '0;
  logic [4:0]  m_out_addr = '0;

  always @(posedge clk) begin
    if (rst) begin
      m_busy = 0; m_done = 0; m_out_data = '0; m_out_addr = '0;
    end else if (flush) begin
      m_busy = 0; m_done = 0;
    end else if (m_done) begin
      m_done = 0;
    end else if (m_busy) begin
      m_left--;
      if (m_left == 0) begin
        m_busy = 0; m_done = 1; m_out_data = m_res; m_out_addr = m_addr;
      end
    end else if (start) begin
      m_busy = 1;
      m_left = is_fast(op, src1, src2) ? 1 : 33;
      m_res  = ref_result(op, src1, src2);
      m_addr = gprs_waddr_i;
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      check("stall", {31'b0, stall},
            {31'b0, !rst && (m_busy || (!m_done && start && !flush))});
      check("done", {31'b0, done}, {31'b0, m_done});
      check("wdata", gprs_wdata_o, m_out_data);
      check("waddr", {27'b0, gprs_waddr_o}, {27'b0, m_out_addr});
    end
  end

  // Called just after a rising edge; returns just after the edge that leaves DONE.
  task automatic run_op(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b,
                        input logic [4:0] addr, input logic [31:0] exp, input bit poke);
    int lat;
    bit seen;
    int want;
    check("model_pin", ref_result(o, a, b), exp);
    want = is_fast(o, a, b) ? 2 : 34;
    op = o; src1 = a; src2 = b; gprs_waddr_i = addr; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    src1 = $urandom; src2 = $urandom;
    op = 3'($urandom_range(0, 7)); gprs_waddr_i = 5'($urandom_range(0, 31));
    seen = 0; lat = 0;
    for (int n = 1; n <= 40 && !seen; n++) begin
      @(negedge clk);
      if (poke && n == 5) start = 1'b1;
      if (poke && n == 6) start = 1'b0;
      if (done) begin seen = 1; lat = n; end
    end
    check("done_seen", {31'b0, seen}, 32'd1);
    check("latency", lat, want);
    check("result", gprs_wdata_o, exp);
    check("dest", {27'b0, gprs_waddr_o}, {27'b0, addr});
    @(posedge clk); #1;
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    repeat (3) @(posedge clk);
    #1;
    chk_en = 1;
    @(negedge clk);
    check("reset_wdata", gprs_wdata_o, 32'h0);
    check("reset_stall", {31'b0, stall}, 32'd1 - 32'd1 + {31'b0, 1'b0} + 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;

    run_op(3'd0, 32'h0000_0007, 32'hFFFF_FFFA, 5'd1,  32'hFFFF_FFD6, 0);
    run_op(3'd3, 32'h0000_0007, 32'hFFFF_FFFA, 5'd2,  32'h0000_0006, 0);
    run_op(3'd1, 32'h0000_0007, 32'hFFFF_FFFA, 5'd3,  32'hFFFF_FFFF, 0);
    run_op(3'd2, 32'hFFFF_FFFF, 32'h0000_0002, 5'd4,  32'hFFFF_FFFF, 0);
    run_op(3'd2, 32'h0000_0002, 32'hFFFF_FFFF, 5'd5,  32'h0000_0001, 0);
    run_op(3'd0, 32'h1234_5678, 32'h0000_0010, 5'd0,  32'h2345_6780, 0);
    run_op(3'd3, 32'h1234_5678, 32'h0000_0010, 5'd6,  32'h0000_0001, 1);
    run_op(3'd4, 32'hFFFF_FFF9, 32'h0000_0002, 5'd7,  32'hFFFF_FFFD, 0);
    run_op(3'd6, 32'hFFFF_FFF9, 32'h0000_0002, 5'd8,  32'hFFFF_FFFF, 0);
    run_op(3'd4, 32'h0000_0007, 32'hFFFF_FFFE, 5'd9,  32'hFFFF_FFFD, 0);
    run_op(3'd6, 32'h0000_0007, 32'hFFFF_FFFE, 5'd10, 32'h0000_0001, 0);
    run_op(3'd5, 32'h0000_0064, 32'h0000_0007, 5'd11, 32'h0000_000E, 1);
    run_op(3'd7, 32'h0000_0064, 32'h0000_0007, 5'd12, 32'h0000_0002, 0);
    run_op(3'd5, 32'hFFFF_FFFF, 32'h0000_0001, 5'd13, 32'hFFFF_FFFF, 0);
    run_op(3'd5, 32'h0000_0005, 32'h0000_0000, 5'd14, 32'hFFFF_FFFF, 0);
    run_op(3'd7, 32'h0000_0005, 32'h0000_0000, 5'd15, 32'h0000_0005, 0);
    run_op(3'd4, 32'hFFFF_FFF9, 32'h0000_0000, 5'd16, 32'hFFFF_FFFF, 0);
    run_op(3'd6, 32'hFFFF_FFF9, 32'h0000_0000, 5'd17, 32'hFFFF_FFF9, 0);
    run_op(3'd4, 32'h8000_0000, 32'hFFFF_FFFF, 5'd18, 32'h8000_0000, 0);
    run_op(3'd6, 32'h8000_0000, 32'hFFFF_FFFF, 5'd19, 32'h0000_0000, 0);

    // Abort a multiply mid-CALC, then restart immediately.
    op = 3'd0; src1 = 32'd3; src2 = 32'd5; gprs_waddr_i = 5'd20; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (9) @(posedge clk);
    #1 flush = 1'b1;
    @(posedge clk); #1;
    flush = 1'b0;
    check("flush_stall", {31'b0, stall}, 32'd0);
    check("flush_done", {31'b0, done}, 32'd0);
    check("flush_hold", gprs_wdata_o, 32'h0000_0000);
    run_op(3'd0, 32'h0000_0009, 32'h0000_000B, 5'd21, 32'h0000_0063, 0);

    // Flush and start together in IDLE: nothing is accepted.
    op = 3'd5; src1 = 32'd50; src2 = 32'd5; start = 1'b1; flush = 1'b1;
    @(posedge clk); #1;
    start = 1'b0; flush = 1'b0;
    repeat (40) @(posedge clk);
    #1;

    // Reset in the middle of a divide with start held high.
    op = 3'd5; src1 = 32'd1000; src2 = 32'd3; gprs_waddr_i = 5'd22; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (19) @(posedge clk);
    #1;
    rst = 1'b1; start = 1'b1; op = 3'd0; src1 = 32'd2; src2 = 32'd2;
    @(negedge clk);
    check("rst_stall", {31'b0, stall}, 32'd0);
    @(posedge clk); #1;
    check("rst_wdata", gprs_wdata_o, 32'h0);
    check("rst_waddr", {27'b0, gprs_waddr_o}, 32'h0);
    check("rst_done", {31'b0, done}, 32'd0);
    @(posedge clk); #1;
    rst = 1'b0; start = 1'b0;
    repeat (40) @(posedge clk);
    #1;
    run_op(3'd7, 32'd1000, 32'd3, 5'd23, 32'd1, 0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
